lockstep_checker: RTL and testbench
===================================

Name: lockstep_checker

Overview:
- Parametrised lockstep/equivalence monitor. Compares two WIDTH-bit output buses from two implementations of the same circuit, cycle by cycle.
- Generalises the two-output miter used in the formal tops:
  - per-side latency skew compensation
  - warm-up window
  - bit mask
  - sticky error with mismatch count and first-mismatch capture
  - optional stop-on-fail
- Instantiated in formal and simulation harnesses next to the two DUT copies. Its outputs feed assertions or a status register.

Parameters:
- WIDTH, 8: bits compared per cycle.
- SKEW_A, 0: cycles of delay inserted on side A before compare (0..15).
- SKEW_B, 0: cycles of delay inserted on side B before compare (0..15).
- WARMUP, 2: CHECK-suppressed cycles after enable (0 = check immediately).
- CNT_W, 8: width of the saturating mismatch counter.
- CYC_W, 16: width of the saturating check-cycle index.
- STOP_ON_FAIL, 0: 1 = freeze in FAIL on first mismatch.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- en_i  in  1  enable monitoring.
- clr_i  in  1  synchronous clear of results; returns the FSM to IDLE.
- a_i  in  WIDTH  side-A bus.
- b_i  in  WIDTH  side-B bus.
- mask_i  in  WIDTH  1 = ignore this bit; applied to the aligned samples, undelayed.
- eq_o  out  1  registered: last compared cycle matched.
- err_o  out  1  sticky mismatch flag.
- err_cnt_o  out  CNT_W  saturating mismatch count.
- first_diff_o  out  WIDTH  masked XOR pattern of the first mismatch.
- first_cyc_o  out  CYC_W  check-cycle index of the first mismatch.
- state_o  out  2  current FSM state.

Behaviour:
- Reset (rst_i=1 at an edge), all outputs and state:
  - eq_o=1, err_o=0, err_cnt_o=0, first_diff_o=0, first_cyc_o=0, state_o=IDLE
  - delay lines zeroed; cycle counters zeroed
  - reset mid-operation behaves identically
- Alignment:
  - a_d = a_i delayed SKEW_A cycles; b_d = b_i delayed SKEW_B cycles; delay 0 = wire.
  - Delay lines shift every cycle regardless of state.
- diff = (a_d ^ b_d) & ~mask_i. A mismatch is diff != 0 while state=CHECK.
- FSM, encoding IDLE=0, WARMUP=1, CHECK=2, FAIL=3:
  - IDLE: if en_i, go to WARMUP (WARMUP>0) or CHECK (WARMUP=0); warm-up counter cleared.
  - WARMUP: counter increments each cycle; at WARMUP-1 go to CHECK. en_i=0 goes to IDLE.
  - CHECK: en_i=0 goes to IDLE. If mismatch and STOP_ON_FAIL=1, go to FAIL.
  - FAIL: holds regardless of en_i; only clr_i or rst_i exit to IDLE.
- Compare stage, each CHECK cycle (results visible the next cycle, latency 1):
  - eq_o <= (diff==0).
  - On mismatch: err_o<=1; err_cnt_o increments, saturating at 2^CNT_W-1.
  - If err_o was 0: first_diff_o<=diff and first_cyc_o<=cyc.
- eq_o holds its last value outside CHECK.
- cyc:
  - 0 on entering CHECK from IDLE/WARMUP
  - +1 per CHECK cycle, saturating at 2^CYC_W-1
  - not cleared by a CHECK->IDLE->CHECK re-entry; only rst_i/clr_i clear it
- Precedence: rst_i > clr_i > mismatch/FSM update.
- clr_i:
  - clears err_o, err_cnt_o, first_*, cyc, eq_o(=1); state returns to IDLE
  - delay lines untouched
  - a mismatch in the same cycle is discarded
- In FAIL: no further counting; captures frozen; eq_o=0.
- Skew >0: samples shifted in before enable remain in the pipe; the WARMUP window covers that fill.

Decomposition:
- lockstep_pkg:
  - state_t enum {IDLE, WARMUP, CHECK, FAIL} (2-bit)
  - MAX_SKEW=15 constant
  - sat_inc function (saturating increment)
- Sub-module delay_line, parameters W and DEPTH:
  - DEPTH=0 is a pass-through; otherwise a synchronous shift register cleared by rst_i.
  - Instantiated once per side.

Test Plan:
- WARMUP=2, SKEW 0/0; en_i=1; a_i=b_i random for 20 cycles -> err_o=0, err_cnt_o=0, eq_o=1, state_o: 1,1,2...
- Mismatch at check cycle 5: a_i=8'h3C, b_i=8'h34 -> next cycle eq_o=0, err_o=1, err_cnt_o=1, first_diff_o=8'h08, first_cyc_o=5; eq_o back to 1 after.
- Same stimulus with mask_i=8'h08 -> no error; eq_o stays 1.
- SKEW_A=2, b_i = a_i delayed 2 in bench -> zero errors. Change the bench delay to 1 -> err_cnt_o increments each cycle where adjacent samples differ.
- CNT_W=3, 10 consecutive mismatches -> err_cnt_o=7 (saturates), first_cyc_o unchanged. Repeat with STOP_ON_FAIL=1: state_o=3 after the first mismatch, err_cnt_o=1, toggling en_i has no effect, clr_i -> IDLE and all cleared.
- rst_i pulsed mid-CHECK with err_o=1 -> next cycle all outputs at reset values. Also clr_i and a mismatch in the same cycle -> err_o=0.

Source files
------------

// File: rtl/lockstep_pkg.sv
// Shared types and helpers for the lockstep/equivalence monitor.
package lockstep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    CHECK  = 2'd2,
    FAIL   = 2'd3
  } state_t;

  // Deepest per-side alignment delay the monitor is intended for.
  localparam int MAX_SKEW = 15;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth alignment pipe; DEPTH=0 degenerates to a wire.
module delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_i;
      assign q_o = d_i;
    end else begin : g_pipe
      logic [W-1:0] stage_q [DEPTH];

      // Shift one stage per cycle, every cycle, independent of the monitor state.
      always_ff @(posedge clk_i) begin
        // NOTE: the pipe is explicitly reset so samples from before reset can
        // never reach the comparator; this small array maps to flops, not RAM.
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          // NOTE: non-blocking assignments make every stage take the value its
          // neighbour held before the edge, giving a true shift register.
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/lockstep_checker.sv
// Cycle-by-cycle equivalence monitor for two copies of the same circuit:
// skew alignment, warm-up window, bit mask, sticky error with first capture.
module lockstep_checker
  import lockstep_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SKEW_A       = 0,
  parameter int SKEW_B       = 0,
  parameter int WARMUP       = 2,
  parameter int CNT_W        = 8,
  parameter int CYC_W        = 16,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic             eq_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0] first_diff_o,
  output logic [CYC_W-1:0] first_cyc_o,
  output logic [1:0]       state_o
);

  localparam int          WU_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WU_W-1:0] WU_LAST = WU_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [31:0] CYC_MAX = 32'((64'd1 << CYC_W) - 64'd1);

  // The WARMUP parameter shadows the state name, so that state is always
  // referenced through the package scope below.
  state_t           state_q, state_d;
  logic [WU_W-1:0]  wu_q;
  logic [CYC_W-1:0] cyc_q;
  logic             eq_q, err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [WIDTH-1:0] first_diff_q;
  logic [CYC_W-1:0] first_cyc_q;

  logic [WIDTH-1:0] a_d, b_d, diff;
  logic             mismatch;

  delay_line #(.W(WIDTH), .DEPTH(SKEW_A)) u_dly_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (a_i),
    .q_o   (a_d)
  );

  delay_line #(.W(WIDTH), .DEPTH(SKEW_B)) u_dly_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (b_i),
    .q_o   (b_d)
  );

  // Mask is applied to the aligned samples, not delayed with them.
  assign diff     = (a_d ^ b_d) & ~mask_i;
  assign mismatch = (state_q == CHECK) && (diff != '0);

  // Next-state logic; clear always wins and returns to IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          if (WARMUP > 0) state_d = lockstep_pkg::WARMUP;
          else            state_d = CHECK;
        end
      end
      lockstep_pkg::WARMUP: begin
        if (!en_i)                 state_d = IDLE;
        else if (wu_q == WU_LAST)  state_d = CHECK;
      end
      CHECK: begin
        if (!en_i)                                state_d = IDLE;
        else if (mismatch && STOP_ON_FAIL != 0)   state_d = FAIL;
      end
      FAIL: state_d = FAIL;
      default: state_d = IDLE;
    endcase
    if (clr_i) state_d = IDLE;
  end

  // State register and warm-up counter (counts only while in WARMUP).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wu_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == lockstep_pkg::WARMUP) wu_q <= wu_q + WU_W'(1);
      else                                 wu_q <= '0;
    end
  end

  // Compare stage: results of a CHECK cycle appear one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      eq_q         <= 1'b1;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      first_diff_q <= '0;
      first_cyc_q  <= '0;
      cyc_q        <= '0;
    end else if (state_q == CHECK) begin
      eq_q  <= (diff == '0);
      cyc_q <= CYC_W'(sat_inc(32'(cyc_q), CYC_MAX));
      if (mismatch) begin
        err_q     <= 1'b1;
        err_cnt_q <= CNT_W'(sat_inc(32'(err_cnt_q), CNT_MAX));
        if (!err_q) begin
          first_diff_q <= diff;
          first_cyc_q  <= cyc_q;
        end
      end
    end else if (state_q == FAIL) begin
      eq_q <= 1'b0;
    end
  end

  assign eq_o         = eq_q;
  assign err_o        = err_q;
  assign err_cnt_o    = err_cnt_q;
  assign first_diff_o = first_diff_q;
  assign first_cyc_o  = first_cyc_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_lockstep_checker.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// and a randomized run against a behavioural model.
module tb_lockstep_checker;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [7:0] a, b0, b1, mask;

  logic       eq0, err0;  logic [7:0] cnt0; logic [7:0] fd0; logic [15:0] fc0; logic [1:0] st0;
  logic       eq1, err1;  logic [7:0] cnt1; logic [7:0] fd1; logic [15:0] fc1; logic [1:0] st1;
  logic       eq2, err2;  logic [2:0] cnt2; logic [7:0] fd2; logic [15:0] fc2; logic [1:0] st2;
  logic       eq3, err3;  logic [2:0] cnt3; logic [7:0] fd3; logic [15:0] fc3; logic [1:0] st3;
  logic       eq4, err4;  logic [3:0] cnt4; logic [7:0] fd4; logic [15:0] fc4; logic [1:0] st4;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Default configuration: WARMUP=2, no skew.
  lockstep_checker u0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .a_i(a), .b_i(b0), .mask_i(mask),
    .eq_o(eq0), .err_o(err0), .err_cnt_o(cnt0), .first_diff_o(fd0), .first_cyc_o(fc0), .state_o(st0));

  // Side A delayed by 2.
  lockstep_checker #(.SKEW_A(2)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .a_i(a), .b_i(b1), .mask_i(mask),
    .eq_o(eq1), .err_o(err1), .err_cnt_o(cnt1), .first_diff_o(fd1), .first_cyc_o(fc1), .state_o(st1));

  // Narrow counter, keeps checking.
  lockstep_checker #(.CNT_W(3)) u2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .a_i(a), .b_i(b0), .mask_i(mask),
    .eq_o(eq2), .err_o(err2), .err_cnt_o(cnt2), .first_diff_o(fd2), .first_cyc_o(fc2), .state_o(st2));

  // Narrow counter, freezes on first failure.
  lockstep_checker #(.CNT_W(3), .STOP_ON_FAIL(1)) u3 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .a_i(a), .b_i(b0), .mask_i(mask),
    .eq_o(eq3), .err_o(err3), .err_cnt_o(cnt3), .first_diff_o(fd3), .first_cyc_o(fc3), .state_o(st3));

  // Randomized target: asymmetric skew, longer warm-up, 4-bit counter.
  localparam int R_SA = 1, R_SB = 3, R_WU = 3, R_CMAX = 15;
  lockstep_checker #(.SKEW_A(R_SA), .SKEW_B(R_SB), .WARMUP(R_WU), .CNT_W(4)) u4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .a_i(a), .b_i(b0), .mask_i(mask),
    .eq_o(eq4), .err_o(err4), .err_cnt_o(cnt4), .first_diff_o(fd4), .first_cyc_o(fc4), .state_o(st4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table (u0) ----------------
  typedef struct {
    logic       en, clr;
    logic [7:0] a, b, mask;
    int         st, eq, err, cnt, fd, fc;
  } vec_t;

  vec_t vt [24];

  // ---------------- behavioural model (u4) ----------------
  // The monitor is "checking" once en has been high for more than WARMUP
  // consecutive prior cycles; "warming" for 1..WARMUP; idle otherwise.
  int         m_streak, m_eq, m_err, m_cnt, m_fd, m_fc, m_cyc;
  logic [7:0] qa [$];
  logic [7:0] qb [$];

  function automatic int phase_of(input int streak);
    if (streak == 0)    return 0;
    if (streak <= R_WU) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_streak = 0; m_eq = 1; m_err = 0; m_cnt = 0; m_fd = 0; m_fc = 0; m_cyc = 0;
    qa.delete(); qb.delete();
    for (int i = 0; i < R_SA; i++) qa.push_back(8'h00);
    for (int i = 0; i < R_SB; i++) qb.push_back(8'h00);
  endtask

  task automatic model_cycle();
    logic [7:0] ad, bd, df;
    qa.push_back(a); ad = qa.pop_front();
    qb.push_back(b0); bd = qb.pop_front();
    df = (ad ^ bd) & ~mask;
    if (clr) begin
      m_eq = 1; m_err = 0; m_cnt = 0; m_fd = 0; m_fc = 0; m_cyc = 0; m_streak = 0;
    end else begin
      if (phase_of(m_streak) == 2) begin
        m_eq = (df == 8'h00) ? 1 : 0;
        if (df != 8'h00) begin
          if (m_err == 0) begin m_fd = int'(df); m_fc = m_cyc; end
          m_err = 1;
          if (m_cnt < R_CMAX) m_cnt++;
        end
        if (m_cyc < 65535) m_cyc++;
      end
      if (en) begin
        if (m_streak < 1000) m_streak++;
      end else begin
        m_streak = 0;
      end
    end
  endtask

  logic [7:0] hist [64];
  logic [7:0] ra [410];
  logic [7:0] ad_s;
  int exp_eq, exp_cnt, exp_fd, exp_fc;
  bit got_first;

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; a = '0; b0 = '0; b1 = '0; mask = '0;

    vt[0]  = '{1'b1, 1'b0, 8'h11, 8'h11, 8'h00, 1, 1, 0, 0, 8'h00, 0};
    vt[1]  = '{1'b1, 1'b0, 8'h22, 8'h22, 8'h00, 1, 1, 0, 0, 8'h00, 0};
    vt[2]  = '{1'b1, 1'b0, 8'h33, 8'h33, 8'h00, 2, 1, 0, 0, 8'h00, 0};
    vt[3]  = '{1'b1, 1'b0, 8'h44, 8'h44, 8'h00, 2, 1, 0, 0, 8'h00, 0};
    vt[4]  = '{1'b1, 1'b0, 8'h55, 8'h55, 8'h00, 2, 1, 0, 0, 8'h00, 0};
    vt[5]  = '{1'b1, 1'b0, 8'h66, 8'h66, 8'h00, 2, 1, 0, 0, 8'h00, 0};
    vt[6]  = '{1'b1, 1'b0, 8'h77, 8'h77, 8'h00, 2, 1, 0, 0, 8'h00, 0};
    vt[7]  = '{1'b1, 1'b0, 8'h88, 8'h88, 8'h00, 2, 1, 0, 0, 8'h00, 0};
    vt[8]  = '{1'b1, 1'b0, 8'h3C, 8'h34, 8'h00, 2, 0, 1, 1, 8'h08, 5};
    vt[9]  = '{1'b1, 1'b0, 8'h99, 8'h99, 8'h00, 2, 1, 1, 1, 8'h08, 5};
    vt[10] = '{1'b1, 1'b0, 8'hAA, 8'hAA, 8'h00, 2, 1, 1, 1, 8'h08, 5};
    vt[11] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 0};
    vt[12] = '{1'b1, 1'b0, 8'h5A, 8'h5A, 8'h00, 1, 1, 0, 0, 8'h00, 0};
    vt[13] = '{1'b1, 1'b0, 8'h5A, 8'h5A, 8'h00, 1, 1, 0, 0, 8'h00, 0};
    vt[14] = '{1'b1, 1'b0, 8'h5A, 8'h5A, 8'h00, 2, 1, 0, 0, 8'h00, 0};
    vt[15] = '{1'b1, 1'b0, 8'h3C, 8'h34, 8'h08, 2, 1, 0, 0, 8'h00, 0};
    vt[16] = '{1'b1, 1'b0, 8'hF0, 8'h0F, 8'h00, 2, 0, 1, 1, 8'hFF, 1};
    vt[17] = '{1'b0, 1'b0, 8'h12, 8'h12, 8'h00, 0, 1, 1, 1, 8'hFF, 1};
    vt[18] = '{1'b0, 1'b0, 8'h01, 8'h02, 8'h00, 0, 1, 1, 1, 8'hFF, 1};
    vt[19] = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 1, 1, 1, 1, 8'hFF, 1};
    vt[20] = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 1, 1, 1, 1, 8'hFF, 1};
    vt[21] = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 2, 1, 1, 1, 8'hFF, 1};
    vt[22] = '{1'b1, 1'b0, 8'h00, 8'h80, 8'h00, 2, 0, 1, 2, 8'hFF, 1};
    vt[23] = '{1'b1, 1'b0, 8'h80, 8'h80, 8'h00, 2, 1, 1, 2, 8'hFF, 1};

    // Reset values.
    do_reset();
    check("rst.st",  32'(st0),  0);
    check("rst.eq",  32'(eq0),  1);
    check("rst.err", 32'(err0), 0);
    check("rst.cnt", 32'(cnt0), 0);
    check("rst.fd",  32'(fd0),  0);
    check("rst.fc",  32'(fc0),  0);

    // Directed table on u0.
    for (int i = 0; i < 24; i++) begin
      en = vt[i].en; clr = vt[i].clr; a = vt[i].a; b0 = vt[i].b; mask = vt[i].mask;
      step();
      check($sformatf("vec%0d.st", i),  32'(st0),  vt[i].st);
      check($sformatf("vec%0d.eq", i),  32'(eq0),  vt[i].eq);
      check($sformatf("vec%0d.err", i), 32'(err0), vt[i].err);
      check($sformatf("vec%0d.cnt", i), 32'(cnt0), vt[i].cnt);
      check($sformatf("vec%0d.fd", i),  32'(fd0),  vt[i].fd);
      check($sformatf("vec%0d.fc", i),  32'(fc0),  vt[i].fc);
    end

    // Reset pulsed mid-CHECK with an error pending and a live mismatch.
    rst = 1'b1; en = 1'b1; clr = 1'b0; a = 8'h01; b0 = 8'h02; mask = 8'h00;
    step();
    rst = 1'b0;
    check("midrst.st",  32'(st0),  0);
    check("midrst.eq",  32'(eq0),  1);
    check("midrst.err", 32'(err0), 0);
    check("midrst.cnt", 32'(cnt0), 0);
    check("midrst.fd",  32'(fd0),  0);
    check("midrst.fc",  32'(fc0),  0);

    // Skew: side A delayed 2; bench delays B by 2, then by 1.
    do_reset();
    exp_eq = 1; exp_cnt = 0; got_first = 1'b0; exp_fd = 0; exp_fc = 0;
    for (int t = 0; t < 60; t++) begin
      int d;
      d = (t < 30) ? 2 : 1;
      hist[t] = 8'($urandom_range(0, 3));
      a = hist[t]; b0 = hist[t]; en = 1'b1; clr = 1'b0; mask = 8'h00;
      b1   = (t >= d) ? hist[t-d] : 8'h00;
      ad_s = (t >= 2) ? hist[t-2] : 8'h00;
      if (t >= 3) begin
        exp_eq = (ad_s == b1) ? 1 : 0;
        if (ad_s != b1) begin
          exp_cnt++;
          if (!got_first) begin
            got_first = 1'b1; exp_fd = int'(ad_s ^ b1); exp_fc = t - 3;
          end
        end
      end
      step();
      check($sformatf("skew%0d.eq", t),  32'(eq1),  exp_eq);
      check($sformatf("skew%0d.cnt", t), 32'(cnt1), exp_cnt);
    end
    check("skew.st",  32'(st1),  2);
    check("skew.err", 32'(err1), got_first ? 1 : 0);
    check("skew.fd",  32'(fd1),  exp_fd);
    check("skew.fc",  32'(fc1),  exp_fc);

    // Saturation (u2) and stop-on-fail (u3) on the same stimulus.
    do_reset();
    en = 1'b1; mask = 8'h00; a = 8'h00; b0 = 8'h00; b1 = 8'h00;
    for (int t = 0; t < 5; t++) step();
    for (int k = 1; k <= 10; k++) begin
      a = 8'h0F; b0 = 8'h0E;
      step();
      check($sformatf("sat%0d.cnt", k), 32'(cnt2), (k < 7) ? k : 7);
      check($sformatf("stop%0d.st", k), 32'(st3), 3);
      check($sformatf("stop%0d.cnt", k), 32'(cnt3), 1);
      check($sformatf("stop%0d.eq", k), 32'(eq3), 0);
    end
    check("sat.err", 32'(err2), 1);
    check("sat.eq",  32'(eq2),  0);
    check("sat.st",  32'(st2),  2);
    check("sat.fd",  32'(fd2),  8'h01);
    check("sat.fc",  32'(fc2),  2);
    check("stop.err", 32'(err3), 1);
    check("stop.fd",  32'(fd3),  8'h01);
    check("stop.fc",  32'(fc3),  2);
    for (int t = 0; t < 6; t++) begin
      en = (t < 3) ? 1'b0 : 1'b1;
      step();
      check($sformatf("stopen%0d.st", t), 32'(st3), 3);
      check($sformatf("stopen%0d.cnt", t), 32'(cnt3), 1);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("stopclr.st",  32'(st3),  0);
    check("stopclr.eq",  32'(eq3),  1);
    check("stopclr.err", 32'(err3), 0);
    check("stopclr.cnt", 32'(cnt3), 0);
    check("stopclr.fd",  32'(fd3),  0);
    check("stopclr.fc",  32'(fc3),  0);
    check("satclr.cnt",  32'(cnt2), 0);

    // Randomized run on u4 against the model. B is A advanced so that, after
    // the two skews, aligned samples match unless deliberately corrupted.
    for (int i = 0; i < 410; i++) ra[i] = 8'($urandom);
    do_reset();
    model_reset();
    for (int t = 0; t < 400; t++) begin
      en   = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 49) == 0);
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      a    = ra[t];
      b0   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ra[t + R_SB - R_SA];
      model_cycle();
      step();
      check($sformatf("rnd%0d.st", t),  32'(st4),  phase_of(m_streak));
      check($sformatf("rnd%0d.eq", t),  32'(eq4),  m_eq);
      check($sformatf("rnd%0d.err", t), 32'(err4), m_err);
      check($sformatf("rnd%0d.cnt", t), 32'(cnt4), m_cnt);
      check($sformatf("rnd%0d.fd", t),  32'(fd4),  m_fd);
      check($sformatf("rnd%0d.fc", t),  32'(fc4),  m_fc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
